// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the multi-port register file: default parameter
//   values, the bulk-clear FSM state type and a ceil-log2 helper used to
//   derive the address width from the entry count.
package regfile_pkg;

    localparam int RF_DW       = 8;
    localparam int RF_DEPTH    = 8;
    localparam int RF_NRD      = 2;
    localparam int RF_BYPASS   = 1;
    localparam int RF_ZERO_REG = 0;

    typedef enum logic {
        RF_IDLE,
        RF_SWEEP
    } rf_state_e;

    // Smallest r with 2**r >= n (n >= 2 in every legal configuration).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port
//   One combinational read port of the register file. Decodes the read
//   address against the flattened entry array, returns 0 for addresses
//   beyond DEPTH-1 and for the hardwired zero entry, and optionally forwards
//   same-cycle accepted write data (port 1 over port 0).
// Ports:
//   raddr     in   AW       read address
//   mem_flat  in   DEPTH*DW all entries, entry i at [i*DW +: DW]
//   wr_acc    in   2        write port p accepted this cycle
//   waddr     in   2*AW     write addresses, port p at [p*AW +: AW]
//   wdata     in   2*DW     write data, port p at [p*DW +: DW]
//   rdata     out  DW       read data
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int DEPTH    = RF_DEPTH,
    parameter int AW       = clog2(DEPTH),
    parameter int BYPASS   = RF_BYPASS,
    parameter int ZERO_REG = RF_ZERO_REG
) (
    input  logic [AW-1:0]       raddr,
    input  logic [DEPTH*DW-1:0] mem_flat,
    input  logic [1:0]          wr_acc,
    input  logic [2*AW-1:0]     waddr,
    input  logic [2*DW-1:0]     wdata,
    output logic [DW-1:0]       rdata
);

    logic [DW-1:0] entry;

    always_comb begin
        // An address that matches no entry (out of range) leaves entry at 0.
        entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == AW'(i)) entry = mem_flat[i*DW +: DW];
        end

        rdata = entry;
        // wr_acc is only ever set for in-range, writable addresses, so the
        // bypass cannot leak data onto an out-of-range read.
        if (BYPASS != 0) begin
            if (wr_acc[1] && (waddr[AW +: AW] == raddr))
                rdata = wdata[DW +: DW];
            else if (wr_acc[0] && (waddr[0 +: AW] == raddr))
                rdata = wdata[0 +: DW];
        end

        if ((ZERO_REG != 0) && (raddr == '0)) rdata = '0;
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised register file with two write ports, NRD combinational read
//   ports, per-entry busy (scoreboard) bits and a bulk-clear engine that
//   zeroes one entry per cycle.
// Ports:
//   clk         in   1         clock, rising edge
//   rst         in   1         asynchronous active-high reset
//   we          in   2         write enable per write port
//   waddr       in   2*AW      write addresses, port p at [p*AW +: AW]
//   wdata       in   2*DW      write data, port p at [p*DW +: DW]
//   wr_ready    out  1         low while the clear sweep runs
//   raddr       in   NRD*AW    read addresses, packed
//   rdata       out  NRD*DW    read data, packed, combinational
//   alloc_en    in   1         mark alloc_addr busy
//   alloc_addr  in   AW        entry to mark busy
//   busy        out  DEPTH     per-entry busy bits
//   clr_req     in   1         start bulk clear
//   clr_busy    out  1         bulk clear in progress
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int DEPTH    = RF_DEPTH,
    parameter int AW       = clog2(DEPTH),
    parameter int NRD      = RF_NRD,
    parameter int BYPASS   = RF_BYPASS,
    parameter int ZERO_REG = RF_ZERO_REG
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          we,
    input  logic [2*AW-1:0]     waddr,
    input  logic [2*DW-1:0]     wdata,
    output logic                wr_ready,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*DW-1:0]   rdata,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic [DEPTH-1:0]    busy,
    input  logic                clr_req,
    output logic                clr_busy
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    rf_state_e                  state, state_nxt;
    logic [AW-1:0]              sweep_cnt;
    logic                       sweep_last;
    logic [DEPTH-1:0][DW-1:0]   mem;
    logic [DEPTH-1:0]           busy_q;
    logic [1:0]                 wr_acc;
    logic                       alloc_ok;

    // In range and not the hardwired zero entry.
    function automatic logic writable(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign sweep_last = (state == RF_SWEEP) && (sweep_cnt == AW'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RF_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        clr_busy  = 1'b0;
        case (state)
            RF_IDLE: begin
                wr_ready = 1'b1;
                if (clr_req) state_nxt = RF_SWEEP;
            end
            RF_SWEEP: begin
                clr_busy = 1'b1;
                if (sweep_last) state_nxt = RF_IDLE;
            end
            default: state_nxt = RF_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sweep_cnt <= '0;
        else if (state == RF_SWEEP)
            sweep_cnt <= sweep_last ? '0 : sweep_cnt + 1'b1;
        else
            sweep_cnt <= '0;
    end

    always_comb begin
        wr_acc = '0;
        for (int p = 0; p < 2; p++) begin
            wr_acc[p] = we[p] && wr_ready && writable(waddr[p*AW +: AW]);
        end
        alloc_ok = alloc_en && writable(alloc_addr);
    end

    // Port 1 is tested first so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (state == RF_SWEEP) begin
                    if (sweep_cnt == AW'(i)) mem[i] <= '0;
                end else if (wr_acc[1] && (waddr[AW +: AW] == AW'(i))) begin
                    mem[i] <= wdata[DW +: DW];
                end else if (wr_acc[0] && (waddr[0 +: AW] == AW'(i))) begin
                    mem[i] <= wdata[0 +: DW];
                end
            end
        end
    end

    // Allocation beats a same-cycle writeback clear; the final sweep edge
    // beats everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else if (sweep_last) begin
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_ok && (alloc_addr == AW'(i)))
                    busy_q[i] <= 1'b1;
                else if ((wr_acc[0] && (waddr[0 +: AW] == AW'(i))) ||
                         (wr_acc[1] && (waddr[AW +: AW] == AW'(i))))
                    busy_q[i] <= 1'b0;
            end
        end
    end

    assign busy = busy_q;

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        regfile_rd_port #(
            .DW       (DW),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .raddr    (raddr[r*AW +: AW]),
            .mem_flat (mem),
            .wr_acc   (wr_acc),
            .waddr    (waddr),
            .wdata    (wdata),
            .rdata    (rdata[r*DW +: DW])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
//   Two instances run side by side: A is the default build (DEPTH 8, bypass,
//   no zero register); B is DEPTH 6, no bypass, zero register enabled, so
//   out-of-range addresses 6 and 7 exist. A behavioural model of entries,
//   busy bits and the clear sweep provides every expected value.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  we [2];
    logic [5:0]  waddr [2];
    logic [15:0] wdata [2];
    logic [5:0]  raddr [2];
    logic        alloc_en [2];
    logic [2:0]  alloc_addr [2];
    logic        clr_req [2];
    logic [15:0] rdata [2];
    logic        wr_ready [2];
    logic        clr_busy [2];
    logic [7:0]  busy_a;
    logic [5:0]  busy_b;

    int checks = 0;
    int errors = 0;

    int dep [2] = '{8, 6};
    bit zr  [2] = '{1'b0, 1'b1};
    bit byp [2] = '{1'b1, 1'b0};

    logic [7:0] m_mem [2][8];
    logic [7:0] m_busy [2];
    bit         m_sweep [2];
    int         m_idx [2];

    always #5 clk = ~clk;

    regfile_mp u_dut_a (
        .clk(clk), .rst(rst), .we(we[0]), .waddr(waddr[0]), .wdata(wdata[0]),
        .wr_ready(wr_ready[0]), .raddr(raddr[0]), .rdata(rdata[0]),
        .alloc_en(alloc_en[0]), .alloc_addr(alloc_addr[0]), .busy(busy_a),
        .clr_req(clr_req[0]), .clr_busy(clr_busy[0])
    );

    regfile_mp #(.DW(8), .DEPTH(6), .NRD(2), .BYPASS(0), .ZERO_REG(1)) u_dut_b (
        .clk(clk), .rst(rst), .we(we[1]), .waddr(waddr[1]), .wdata(wdata[1]),
        .wr_ready(wr_ready[1]), .raddr(raddr[1]), .rdata(rdata[1]),
        .alloc_en(alloc_en[1]), .alloc_addr(alloc_addr[1]), .busy(busy_b),
        .clr_req(clr_req[1]), .clr_busy(clr_busy[1])
    );

    // ---------------- reference model ----------------
    function automatic bit addr_ok(int n, logic [2:0] a);
        return (int'(a) < dep[n]) && !(zr[n] && a == 3'd0);
    endfunction

    function automatic logic [7:0] exp_rd(int n, logic [2:0] a);
        if (int'(a) >= dep[n] || (zr[n] && a == 3'd0)) return 8'h00;
        if (byp[n] && !m_sweep[n])
            for (int p = 1; p >= 0; p--)
                if (we[n][p] && addr_ok(n, waddr[n][p*3 +: 3]) && waddr[n][p*3 +: 3] == a)
                    return wdata[n][p*8 +: 8];
        return m_mem[n][a];
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 8; i++) m_mem[n][i] = 8'h00;
            m_busy[n] = 8'h00;
            m_sweep[n] = 1'b0;
            m_idx[n] = 0;
        end
    endfunction

    function automatic void model_edge();
        for (int n = 0; n < 2; n++) begin
            if (m_sweep[n]) begin
                m_mem[n][m_idx[n]] = 8'h00;
                m_idx[n]++;
                if (m_idx[n] == dep[n]) begin
                    m_sweep[n] = 1'b0;
                    m_busy[n] = 8'h00;
                end else if (alloc_en[n] && addr_ok(n, alloc_addr[n])) begin
                    m_busy[n][alloc_addr[n]] = 1'b1;
                end
            end else begin
                for (int p = 0; p < 2; p++)
                    if (we[n][p] && addr_ok(n, waddr[n][p*3 +: 3])) begin
                        m_mem[n][waddr[n][p*3 +: 3]] = wdata[n][p*8 +: 8];
                        m_busy[n][waddr[n][p*3 +: 3]] = 1'b0;
                    end
                if (alloc_en[n] && addr_ok(n, alloc_addr[n]))
                    m_busy[n][alloc_addr[n]] = 1'b1;
                if (clr_req[n]) begin
                    m_sweep[n] = 1'b1;
                    m_idx[n] = 0;
                end
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        for (int n = 0; n < 2; n++) begin
            we[n] = 2'b00; waddr[n] = 6'd0; wdata[n] = 16'h0000; raddr[n] = 6'd0;
            alloc_en[n] = 1'b0; alloc_addr[n] = 3'd0; clr_req[n] = 1'b0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        raddr[0] = 6'o53; raddr[1] = 6'o21;
        repeat (2) @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (rdata[n] !== 16'h0000) begin errors++; $display("FAIL reset_rdata inst%0d: got %h expected 0000", n, rdata[n]); end
            checks++;
            if (clr_busy[n] !== 1'b0 || wr_ready[n] !== 1'b1) begin
                errors++; $display("FAIL reset_flags inst%0d: clr_busy %b wr_ready %b expected 0 1", n, clr_busy[n], wr_ready[n]);
            end
        end
        checks++;
        if (busy_a !== 8'h00 || busy_b !== 6'h00) begin errors++; $display("FAIL reset_busy: got %h/%h expected 0/0", busy_a, busy_b); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_bypass();
        for (int n = 0; n < 2; n++) begin
            we[n] = 2'b01; waddr[n] = {3'd0, 3'd3}; wdata[n] = 16'h00A5; raddr[n] = {3'd0, 3'd3};
        end
        #1;
        checks++;
        if (rdata[0][7:0] !== 8'hA5) begin errors++; $display("FAIL bypass_same_cycle: got %h expected a5", rdata[0][7:0]); end
        checks++;
        if (rdata[1][7:0] !== 8'h00) begin errors++; $display("FAIL nobypass_same_cycle: got %h expected 00", rdata[1][7:0]); end
        tick();
        we[0] = 2'b00; we[1] = 2'b00;
        #1;
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (rdata[n][7:0] !== 8'hA5) begin errors++; $display("FAIL write_next_cycle inst%0d: got %h expected a5", n, rdata[n][7:0]); end
        end
    endtask

    task automatic test_same_addr();
        for (int n = 0; n < 2; n++) begin
            we[n] = 2'b11; waddr[n] = {3'd5, 3'd5}; wdata[n] = 16'h2211; raddr[n] = {3'd5, 3'd5};
        end
        tick();
        idle_inputs();
        for (int n = 0; n < 2; n++) raddr[n] = {3'd5, 3'd5};
        #1;
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (rdata[n] !== 16'h2222) begin errors++; $display("FAIL port1_wins inst%0d: got %h expected 2222", n, rdata[n]); end
        end
    endtask

    task automatic test_busy();
        for (int n = 0; n < 2; n++) begin alloc_en[n] = 1'b1; alloc_addr[n] = 3'd2; end
        tick();
        checks++;
        if (busy_a[2] !== 1'b1 || busy_b[2] !== 1'b1) begin errors++; $display("FAIL alloc_sets_busy: got %b/%b expected 1/1", busy_a[2], busy_b[2]); end
        for (int n = 0; n < 2; n++) begin alloc_en[n] = 1'b0; we[n] = 2'b01; waddr[n] = {3'd0, 3'd2}; wdata[n] = 16'h0033; end
        tick();
        checks++;
        if (busy_a[2] !== 1'b0 || busy_b[2] !== 1'b0) begin errors++; $display("FAIL write_clears_busy: got %b/%b expected 0/0", busy_a[2], busy_b[2]); end
        for (int n = 0; n < 2; n++) begin alloc_en[n] = 1'b1; we[n] = 2'b10; waddr[n] = {3'd2, 3'd0}; wdata[n] = 16'h4400; end
        tick();
        checks++;
        if (busy_a[2] !== 1'b1 || busy_b[2] !== 1'b1) begin errors++; $display("FAIL alloc_beats_write: got %b/%b expected 1/1", busy_a[2], busy_b[2]); end
        checks++;
        if (busy_a !== m_busy[0] || busy_b !== m_busy[1][5:0]) begin
            errors++; $display("FAIL busy_vector: got %h/%h expected %h/%h", busy_a, busy_b, m_busy[0], m_busy[1][5:0]);
        end
        idle_inputs();
    endtask

    task automatic test_zero_range();
        for (int n = 0; n < 2; n++) begin
            we[n] = 2'b01; waddr[n] = 6'd0; wdata[n] = 16'h00FF; alloc_en[n] = 1'b1; alloc_addr[n] = 3'd0; raddr[n] = 6'd0;
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rdata[1][7:0] !== 8'h00 || busy_b[0] !== 1'b0) begin errors++; $display("FAIL zero_reg: rdata %h busy0 %b expected 00 0", rdata[1][7:0], busy_b[0]); end
        checks++;
        if (rdata[0][7:0] !== 8'hFF || busy_a[0] !== 1'b1) begin errors++; $display("FAIL entry0_normal: rdata %h busy0 %b expected ff 1", rdata[0][7:0], busy_a[0]); end
        we[1] = 2'b11; waddr[1] = {3'd7, 3'd6}; wdata[1] = 16'hAABB; alloc_en[1] = 1'b1; alloc_addr[1] = 3'd7; raddr[1] = {3'd7, 3'd6};
        tick();
        idle_inputs();
        raddr[1] = {3'd7, 3'd6};
        #1;
        checks++;
        if (rdata[1] !== 16'h0000) begin errors++; $display("FAIL out_of_range_read: got %h expected 0000", rdata[1]); end
        checks++;
        if (busy_b !== m_busy[1][5:0]) begin errors++; $display("FAIL out_of_range_alloc: got %h expected %h", busy_b, m_busy[1][5:0]); end
    endtask

    task automatic test_sweep();
        int hi_cnt [2];
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 2; n++) begin
                we[n] = 2'b11; waddr[n] = {3'(2*i+1), 3'(2*i)}; wdata[n] = 16'hC3C3;
            end
            tick();
        end
        idle_inputs();
        clr_req[0] = 1'b1; clr_req[1] = 1'b1;
        tick();
        clr_req[0] = 1'b0; clr_req[1] = 1'b0;
        hi_cnt[0] = 0; hi_cnt[1] = 0;
        for (int c = 0; c < 10; c++) begin
            for (int n = 0; n < 2; n++) begin
                raddr[n] = {3'(c + 1), 3'(c)};
                we[n] = (c < 5) ? 2'b11 : 2'b00;
                waddr[n] = {3'(c + 1), 3'(c + 1)}; wdata[n] = 16'h5A5A;
                alloc_en[n] = (c < 4); alloc_addr[n] = 3'(c + 1);
                clr_req[n] = (c == 2);
            end
            #1;
            for (int n = 0; n < 2; n++) begin
                if (clr_busy[n] === 1'b1) hi_cnt[n]++;
                checks++;
                if (wr_ready[n] !== !clr_busy[n]) begin errors++; $display("FAIL sweep_ready inst%0d c%0d: wr_ready %b clr_busy %b", n, c, wr_ready[n], clr_busy[n]); end
            end
            if (c < 8) begin
                checks++;
                if (rdata[0][7:0] !== 8'hC3) begin errors++; $display("FAIL sweep_unswept c%0d: got %h expected c3", c, rdata[0][7:0]); end
            end
            tick();
            for (int n = 0; n < 2; n++) begin
                for (int r = 0; r < 2; r++) begin
                    checks++;
                    if (rdata[n][r*8 +: 8] !== exp_rd(n, raddr[n][r*3 +: 3])) begin
                        errors++; $display("FAIL sweep_read inst%0d c%0d port%0d: got %h expected %h", n, c, r, rdata[n][r*8 +: 8], exp_rd(n, raddr[n][r*3 +: 3]));
                    end
                end
                checks++;
                if (clr_busy[n] !== m_sweep[n]) begin errors++; $display("FAIL sweep_clr_busy inst%0d c%0d: got %b expected %b", n, c, clr_busy[n], m_sweep[n]); end
            end
            if (c < 8) begin
                checks++;
                if (rdata[0][7:0] !== 8'h00) begin errors++; $display("FAIL sweep_zeroed c%0d: got %h expected 00", c, rdata[0][7:0]); end
            end
        end
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (hi_cnt[n] !== dep[n]) begin errors++; $display("FAIL sweep_length inst%0d: got %0d expected %0d", n, hi_cnt[n], dep[n]); end
        end
        checks++;
        if (busy_a !== 8'h00 || busy_b !== 6'h00) begin errors++; $display("FAIL sweep_busy_clear: got %h/%h expected 0/0", busy_a, busy_b); end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                we[n] = 2'($urandom_range(0, 3));
                waddr[n] = 6'($urandom); wdata[n] = 16'($urandom); raddr[n] = 6'($urandom);
                alloc_en[n] = ($urandom_range(0, 2) == 0); alloc_addr[n] = 3'($urandom);
                clr_req[n] = ($urandom_range(0, 40) == 0);
            end
            #1;
            for (int n = 0; n < 2; n++)
                for (int r = 0; r < 2; r++) begin
                    checks++;
                    if (rdata[n][r*8 +: 8] !== exp_rd(n, raddr[n][r*3 +: 3])) begin
                        errors++; $display("FAIL rand_read inst%0d cyc%0d port%0d: got %h expected %h", n, cyc, r, rdata[n][r*8 +: 8], exp_rd(n, raddr[n][r*3 +: 3]));
                    end
                end
            tick();
            checks++;
            if (busy_a !== m_busy[0] || busy_b !== m_busy[1][5:0]) begin
                errors++; $display("FAIL rand_busy cyc%0d: got %h/%h expected %h/%h", cyc, busy_a, busy_b, m_busy[0], m_busy[1][5:0]);
            end
            for (int n = 0; n < 2; n++) begin
                checks++;
                if (clr_busy[n] !== m_sweep[n] || wr_ready[n] !== !m_sweep[n]) begin
                    errors++; $display("FAIL rand_flags inst%0d cyc%0d: clr_busy %b wr_ready %b expected sweep %b", n, cyc, clr_busy[n], wr_ready[n], m_sweep[n]);
                end
            end
        end
        idle_inputs();
        repeat (10) tick();
    endtask

    task automatic test_reset_mid_sweep();
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 2; n++) begin
                we[n] = 2'b11; waddr[n] = {3'(2*i+1), 3'(2*i)}; wdata[n] = 16'($urandom) | 16'h0101;
            end
            tick();
        end
        idle_inputs();
        clr_req[0] = 1'b1; clr_req[1] = 1'b1;
        tick();
        idle_inputs();
        repeat (3) tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (clr_busy[n] !== 1'b0 || wr_ready[n] !== 1'b1) begin
                errors++; $display("FAIL rst_mid_sweep_flags inst%0d: clr_busy %b wr_ready %b expected 0 1", n, clr_busy[n], wr_ready[n]);
            end
        end
        for (int a = 0; a < 8; a++) begin
            raddr[0] = {3'(a), 3'(a)}; raddr[1] = {3'(a), 3'(a)};
            #1;
            checks++;
            if (rdata[0] !== 16'h0000 || rdata[1] !== 16'h0000) begin
                errors++; $display("FAIL rst_mid_sweep_entry%0d: got %h/%h expected 0000/0000", a, rdata[0], rdata[1]);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (clr_busy[0] !== 1'b0 || clr_busy[1] !== 1'b0) begin errors++; $display("FAIL rst_mid_sweep_stays_idle: got %b/%b expected 0/0", clr_busy[0], clr_busy[1]); end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_same_addr();
        test_busy();
        test_zero_range();
        test_sweep();
        test_random();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
